volume_pregain_axil_regs: RTL and testbench
===========================================

// Module: volume_pregain_axil_regs
// PURPOSE
// - AXI4-Lite responder for the Volume_Pregain IP: 4x32 R/W register file plus stereo gain datapath.
// - PS/BFM initiator writes per-channel gain; block applies it to 24-bit signed L/R samples ahead of the mixer.
// - 2-stage pipeline, saturating output, no backpressure.
// PARAMETERS
// C_S00_AXI_DATA_WIDTH  32  AXI data width; fixed at 32.
// C_S00_AXI_ADDR_WIDTH  5   byte address width; decodes 0x00-0x10.
// SAMPLE_W              24  signed audio sample width.
// PORTS
// s00_axi_aclk     in   1   single clock, all logic on its rising edge
// s00_axi_areset   in   1   synchronous, active-high reset
// s00_axi_awaddr   in   5   write address
// s00_axi_awprot   in   3   ignored
// s00_axi_awvalid/awready  in/out 1  write address handshake
// s00_axi_wdata    in   32  write data
// s00_axi_wstrb    in   4   byte enables
// s00_axi_wvalid/wready    in/out 1  write data handshake
// s00_axi_bresp    out  2   always 2'b00 (OKAY)
// s00_axi_bvalid/bready    out/in 1  write response handshake
// s00_axi_araddr   in   5   read address; s00_axi_arprot in 3 ignored
// s00_axi_arvalid/arready  in/out 1  read address handshake
// s00_axi_rdata    out  32  read data; s00_axi_rresp out 2 always OKAY
// s00_axi_rvalid/rready    out/in 1  read data handshake
// smp_in_valid     in   1   input sample strobe
// smp_in_l/r       in   24  signed input samples
// smp_out_valid    out  1   output strobe, smp_in_valid delayed 2 cycles
// smp_out_l/r      out  24  gained, saturated samples
// BEHAVIOUR
// - Reset (sync, high): all ready/valid outputs 0, rdata 0, bresp/rresp 0, smp_out_* 0, pipeline valids 0,
//   REG0=0x0100_0100 (unity both), REG1..REG3=0; in-flight AXI transactions are dropped.
// - Map (addr[4:2]): 0 REG0 {gain_r[31:16],gain_l[15:0]}; 1 REG1 bit0=bypass, others stored;
//   2,3 REG2/REG3 scratch; 4 status (see CONFIGURATION); others read 0, writes ignored, OKAY.
// - REG0..REG3 fully R/W, 32 bits; write applies wstrb per byte; readback equals last write.
// - Write: awready=wready=1 for exactly one cycle when awvalid&wvalid&!bvalid; register updates same edge;
//   bvalid=1 next cycle, held until bready. AW without W (or W without AW) waits; no outstanding writes >1.
// - Read: arready=1 one cycle when arvalid&!rvalid; rdata captured same edge; rvalid next cycle, held with
//   rdata stable until rready. Read and write may complete in the same cycle; read returns pre-write value.
// - Gain: unsigned Q8.8 (0x0100=1.0, 0xFFFF~255.996). Stage1: prod = sample(24s) * {1'b0,gain}(17s) -> 41s.
//   Stage2: prod>>>8 (arithmetic), saturate to [-2^23, 2^23-1]. Latency 2 cycles, 1 sample/cycle throughput.
// - Bypass=1: smp_out = smp_in, still 2-cycle latency. Gain/bypass sampled at stage1 capture; a write taking
//   effect on edge N affects samples captured at edge N+1 onward, never mid-pipeline.
// - smp_out_l/r hold last value when smp_out_valid=0.
// CONFIGURATION
// - VOLUME_PREGAIN_CLIP_CNT_EN defined: status 0x10 = 32-bit clip counter, +1 per output sample where L or R
//   saturated (+1 even if both), saturates at 0xFFFF_FFFF; any write to 0x10 clears it (clear wins over
//   same-cycle increment); reset clears it.
// - Not defined: no counter logic; 0x10 reads 0, writes ignored, still OKAY.
// TESTING
// - Reset, write 0x0101FFFF/0xabcd0001/0xdead0011/0xbeef0011 to 0x00/0x04/0x08/0x0C, read each -> exact match, OKAY.
// - wstrb=4'b0010 write 0x0000AA00 to 0x08 after 0xdead0011 -> reads 0xdeadaa11.
// - REG0=0x0100_0100, REG1=0, in L=0x123456 R=0xFEDCBA -> 2 cycles later out L=0x123456 R=0xFEDCBA.
// - REG0=0x0200_0080 (R x2, L x0.5), in L=0x000100 R=0x400000 -> L=0x000080, R=0x7FFFFF saturated;
//   with CLIP_CNT_EN 0x10 reads 1, write 0x10 -> reads 0.
// - Stall: hold bready/rready=0 10 cycles -> bvalid/rvalid and rdata stable, no second awready/arready.
// - Assert reset during bvalid=1 and pipeline full -> next cycle bvalid=0, smp_out_valid=0, REG0=0x01000100.

Source files
------------

// File: rtl/volume_pregain_axil_regs.sv
// AXI4-Lite 4x32 register file driving a 2-stage stereo Q8.8 gain with saturation; no sample backpressure.
// Optional build macro VOLUME_PREGAIN_CLIP_CNT_EN adds a saturating clip counter at status address 0x10.
module volume_pregain_axil_regs #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5,
  parameter int SAMPLE_W             = 24
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic                              smp_in_valid,
  input  logic [SAMPLE_W-1:0]               smp_in_l,
  input  logic [SAMPLE_W-1:0]               smp_in_r,
  output logic                              smp_out_valid,
  output logic [SAMPLE_W-1:0]               smp_out_l,
  output logic [SAMPLE_W-1:0]               smp_out_r
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int PW = SAMPLE_W + 17;

  logic          r_axi_wrdy, r_bvalid, r_arready, r_rvalid;
  logic [DW-1:0] r_rdata, r_reg0, r_reg1, r_reg2, r_reg3;
  logic          r_s1_vld, r_out_vld;
  logic [PW-1:0] r_prod_l, r_prod_r;
  logic [SAMPLE_W-1:0] r_out_l, r_out_r;

  logic          w_wr_hs, w_rd_hs;
  logic [2:0]    w_wr_idx, w_rd_idx;
  logic [DW-1:0] w_rd_dat, w_status;
  logic [15:0]   w_gain_l, w_gain_r;
  logic [SAMPLE_W:0] w_sat_l, w_sat_r;
  logic          w_unused;

  // Sign-extended sample times zero-extended gain; both operands at full product width.
  function automatic logic [PW-1:0] f_mul(input logic [SAMPLE_W-1:0] s, input logic [15:0] g);
    f_mul = {{(PW-SAMPLE_W){s[SAMPLE_W-1]}}, s} * {{(PW-16){1'b0}}, g};
  endfunction

  // Returns {clipped, value} for prod >>> 8 clamped to the signed sample range.
  function automatic logic [SAMPLE_W:0] f_sat(input logic [PW-1:0] p);
    logic [PW-SAMPLE_W-8:0] top;
    top = p[PW-1:SAMPLE_W+7];
    if (top == '0 || top == '1) f_sat = {1'b0, p[SAMPLE_W+7:8]};
    else if (p[PW-1])           f_sat = {1'b1, 1'b1, {(SAMPLE_W-1){1'b0}}};
    else                        f_sat = {1'b1, 1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  assign w_wr_hs  = r_axi_wrdy & s00_axi_awvalid & s00_axi_wvalid;
  assign w_rd_hs  = r_arready & s00_axi_arvalid;
  assign w_wr_idx = s00_axi_awaddr[4:2];
  assign w_rd_idx = s00_axi_araddr[4:2];

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_axi_wrdy <= 1'b0;
      r_bvalid   <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_reg0     <= 32'h0100_0100;
      r_reg1     <= '0;
      r_reg2     <= '0;
      r_reg3     <= '0;
    end else begin
      r_axi_wrdy <= s00_axi_awvalid & s00_axi_wvalid & ~r_axi_wrdy & ~r_bvalid;
      if (w_wr_hs)             r_bvalid <= 1'b1;
      else if (s00_axi_bready) r_bvalid <= 1'b0;
      if (w_wr_hs) begin
        for (int b = 0; b < DW/8; b++) begin
          if (s00_axi_wstrb[b]) begin
            case (w_wr_idx)
              3'd0:    r_reg0[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
              3'd1:    r_reg1[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
              3'd2:    r_reg2[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
              3'd3:    r_reg3[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
              default: ;
            endcase
          end
        end
      end
      r_arready <= s00_axi_arvalid & ~r_arready & ~r_rvalid;
      // rdata captured from pre-write register values when a write lands on the same edge.
      if (w_rd_hs) begin
        r_rdata  <= w_rd_dat;
        r_rvalid <= 1'b1;
      end else if (s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_dat = '0;
    case (w_rd_idx)
      3'd0:    w_rd_dat = r_reg0;
      3'd1:    w_rd_dat = r_reg1;
      3'd2:    w_rd_dat = r_reg2;
      3'd3:    w_rd_dat = r_reg3;
      3'd4:    w_rd_dat = w_status;
      default: w_rd_dat = '0;
    endcase
  end

  // Bypass forces unity gain, so it shares the multiply path and keeps the same latency.
  assign w_gain_l = r_reg1[0] ? 16'h0100 : r_reg0[15:0];
  assign w_gain_r = r_reg1[0] ? 16'h0100 : r_reg0[31:16];
  assign w_sat_l  = f_sat(r_prod_l);
  assign w_sat_r  = f_sat(r_prod_r);

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_prod_l  <= '0;
      r_prod_r  <= '0;
      r_out_l   <= '0;
      r_out_r   <= '0;
    end else begin
      r_s1_vld  <= smp_in_valid;
      r_out_vld <= r_s1_vld;
      if (smp_in_valid) begin
        r_prod_l <= f_mul(smp_in_l, w_gain_l);
        r_prod_r <= f_mul(smp_in_r, w_gain_r);
      end
      if (r_s1_vld) begin
        r_out_l <= w_sat_l[SAMPLE_W-1:0];
        r_out_r <= w_sat_r[SAMPLE_W-1:0];
      end
    end
  end

`ifdef VOLUME_PREGAIN_CLIP_CNT_EN
  logic [DW-1:0] r_clip_cnt;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset)
      r_clip_cnt <= '0;
    else if (w_wr_hs && w_wr_idx == 3'd4)
      r_clip_cnt <= '0;
    else if (r_s1_vld && (w_sat_l[SAMPLE_W] || w_sat_r[SAMPLE_W]) && r_clip_cnt != '1)
      r_clip_cnt <= r_clip_cnt + 1'b1;
  end

  assign w_status = r_clip_cnt;
`else
  assign w_status = '0;
`endif

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                      w_sat_l[SAMPLE_W], w_sat_r[SAMPLE_W]};

  assign s00_axi_awready = r_axi_wrdy;
  assign s00_axi_wready  = r_axi_wrdy;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign smp_out_valid   = r_out_vld;
  assign smp_out_l       = r_out_l;
  assign smp_out_r       = r_out_r;

endmodule

// File: tb/tb_volume_pregain_axil_regs.sv
// Bench for volume_pregain_axil_regs: AXI-Lite register access, gain pipeline against an arithmetic model,
// stalls, same-cycle read/write and mid-flight reset.
module tb_volume_pregain_axil_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        smp_in_valid, smp_out_valid;
  logic [23:0] smp_in_l, smp_in_r, smp_out_l, smp_out_r;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_reg [4];
  logic [31:0] m_clip;
  logic [23:0] m_last_l, m_last_r;

  typedef struct {
    bit          v;
    logic [23:0] l;
    logic [23:0] r;
    bit          c;
  } exp_t;

  always #5 clk = ~clk;

  volume_pregain_axil_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .smp_in_valid    (smp_in_valid),
    .smp_in_l        (smp_in_l),
    .smp_in_r        (smp_in_r),
    .smp_out_valid   (smp_out_valid),
    .smp_out_l       (smp_out_l),
    .smp_out_r       (smp_out_r)
  );

  task automatic model_reset();
    m_reg[0] = 32'h0100_0100;
    m_reg[1] = '0;
    m_reg[2] = '0;
    m_reg[3] = '0;
    m_clip   = '0;
    m_last_l = '0;
    m_last_r = '0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[4:2]);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
    end else if (idx == 4) begin
      m_clip = '0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int idx;
    idx = int'(a[4:2]);
    if (idx < 4) return m_reg[idx];
`ifdef VOLUME_PREGAIN_CLIP_CNT_EN
    if (idx == 4) return m_clip;
`endif
    return 32'h0;
  endfunction

  // Real-valued view: sample * gain/256, floored, clamped to the 24-bit signed range.
  function automatic logic [23:0] ref_gain(input logic [23:0] s, input logic [15:0] g,
                                           input bit byp, output bit clip);
    longint p;
    clip = 1'b0;
    if (byp) return s;
    p = longint'($signed(s)) * longint'(g);
    p = p >>> 8;
    if (p > 64'sd8388607) begin
      clip = 1'b1;
      return 24'h7FFFFF;
    end
    if (p < -64'sd8388608) begin
      clip = 1'b1;
      return 24'h800000;
    end
    return p[23:0];
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bit hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = awready && wready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (hs) model_write(a, d, s);
    n_vec++;
    if (!hs) begin n_err++; $display("FAIL wr_handshake addr=%h got awready=0 required 1", a); end
    for (int i = 0; i < 20 && !bvalid; i++) begin @(posedge clk); #1; end
    n_vec++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_err++; $display("FAIL wr_resp addr=%h got bvalid=%b bresp=%b required 1/00", a, bvalid, bresp);
    end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    bit hs;
    araddr = a; arvalid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    n_vec++;
    if (!hs) begin n_err++; $display("FAIL rd_handshake addr=%h got arready=0 required 1", a); end
    for (int i = 0; i < 20 && !rvalid; i++) begin @(posedge clk); #1; end
    n_vec++;
    if (rvalid !== 1'b1 || rresp !== 2'b00) begin
      n_err++; $display("FAIL rd_resp addr=%h got rvalid=%b rresp=%b required 1/00", a, rvalid, rresp);
    end
    d = rdata;
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
  endtask

  task automatic check_read(input logic [4:0] a, input string name);
    logic [31:0] got, exp;
    exp = model_read(a);
    axi_read(a, got);
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s addr=%h got %h required %h", name, a, got, exp);
    end
  endtask

  task automatic run_stream(input int n, input int pct, input bit directed,
                            input logic [23:0] dl, input logic [23:0] dr);
    exp_t q[$];
    exp_t e, o;
    bit cl, cr, byp;
    logic [15:0] gl, gr;
    gl = m_reg[0][15:0]; gr = m_reg[0][31:16]; byp = m_reg[1][0];
    for (int k = 0; k < n + 2; k++) begin
      if (k >= 2) begin
        o = q.pop_front();
        n_vec++;
        if (o.v) begin
          if (smp_out_valid !== 1'b1 || smp_out_l !== o.l || smp_out_r !== o.r) begin
            n_err++;
            $display("FAIL smp_out k=%0d got v=%b l=%h r=%h required v=1 l=%h r=%h",
                     k, smp_out_valid, smp_out_l, smp_out_r, o.l, o.r);
          end
          m_last_l = o.l; m_last_r = o.r;
          if (o.c && m_clip != 32'hFFFF_FFFF) m_clip = m_clip + 32'd1;
        end else if (smp_out_valid !== 1'b0 || smp_out_l !== m_last_l || smp_out_r !== m_last_r) begin
          n_err++;
          $display("FAIL smp_hold k=%0d got v=%b l=%h r=%h required v=0 l=%h r=%h",
                   k, smp_out_valid, smp_out_l, smp_out_r, m_last_l, m_last_r);
        end
      end
      e.v = 1'b0; e.l = '0; e.r = '0; e.c = 1'b0;
      if (k < n) begin
        e.v = directed ? 1'b1 : ($urandom_range(99) < pct);
        smp_in_l = directed ? dl : 24'($urandom);
        smp_in_r = directed ? dr : 24'($urandom);
        if ($urandom_range(3) == 0 && !directed) smp_in_l = 24'($signed(8'($urandom)));
        e.l = ref_gain(smp_in_l, gl, byp, cl);
        e.r = ref_gain(smp_in_r, gr, byp, cr);
        e.c = cl | cr;
      end
      smp_in_valid = e.v;
      q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_vec++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0 ||
        bresp !== 2'b00 || rresp !== 2'b00) begin
      n_err++; $display("FAIL reset_axi got rdy/vld=%b%b%b%b%b rdata=%h required 0",
                        awready, wready, bvalid, arready, rvalid, rdata);
    end
    n_vec++;
    if (smp_out_valid !== 1'b0 || smp_out_l !== 24'h0 || smp_out_r !== 24'h0) begin
      n_err++; $display("FAIL reset_smp got v=%b l=%h r=%h required 0", smp_out_valid, smp_out_l, smp_out_r);
    end
    for (int a = 0; a < 8; a++) check_read(5'(a * 4), "reset_regs");
  endtask

  task automatic test_regs();
    logic [4:0]  a;
    axi_write(5'h00, 32'h0101FFFF, 4'hF);
    axi_write(5'h04, 32'habcd0001, 4'hF);
    axi_write(5'h08, 32'hdead0011, 4'hF);
    axi_write(5'h0C, 32'hbeef0011, 4'hF);
    for (int i = 0; i < 4; i++) check_read(5'(i * 4), "regs_rw");
    axi_write(5'h08, 32'h0000AA00, 4'b0010);
    check_read(5'h08, "wstrb_byte1");
    axi_write(5'h14, 32'h12345678, 4'hF);
    check_read(5'h14, "unmapped");
    for (int i = 0; i < 12; i++) begin
      a = 5'($urandom_range(7) * 4);
      axi_write(a, $urandom, 4'($urandom));
      check_read(5'($urandom_range(7) * 4), "rand_rw");
    end
  endtask

  task automatic test_unity();
    axi_write(5'h00, 32'h0100_0100, 4'hF);
    axi_write(5'h04, 32'h0, 4'hF);
    axi_write(5'h10, 32'h0, 4'hF);
    run_stream(1, 100, 1'b1, 24'h123456, 24'hFEDCBA);
    run_stream(3, 100, 1'b1, 24'h800000, 24'h7FFFFF);
  endtask

  task automatic test_saturate();
    axi_write(5'h00, 32'h0200_0080, 4'hF);
    run_stream(1, 100, 1'b1, 24'h000100, 24'h400000);
    check_read(5'h10, "clip_count");
    axi_write(5'h10, 32'h0, 4'hF);
    check_read(5'h10, "clip_clear");
  endtask

  task automatic test_random_gain();
    logic [31:0] g;
    for (int r = 0; r < 6; r++) begin
      g[15:0]  = ($urandom_range(1) == 0) ? 16'($urandom_range(1023)) : 16'($urandom);
      g[31:16] = ($urandom_range(1) == 0) ? 16'($urandom_range(1023)) : 16'($urandom);
      axi_write(5'h00, g, 4'hF);
      axi_write(5'h04, {31'($urandom), ($urandom_range(3) == 0)}, 4'hF);
      run_stream(40, 70, 1'b0, 24'h0, 24'h0);
      check_read(5'h10, "clip_count_rand");
    end
    axi_write(5'h04, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] old, nw;
    bit wdone, rdone, wh, rh;
    old = m_reg[3]; nw = $urandom;
    awaddr = 5'h0C; wdata = nw; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h0C; arvalid = 1'b1;
    wdone = 1'b0; rdone = 1'b0;
    for (int i = 0; i < 20 && !(wdone && rdone); i++) begin
      wh = awready && wready && awvalid;
      rh = arready && arvalid;
      @(posedge clk); #1;
      if (wh) begin wdone = 1'b1; awvalid = 1'b0; wvalid = 1'b0; end
      if (rh) begin rdone = 1'b1; arvalid = 1'b0; end
    end
    for (int i = 0; i < 20 && !(bvalid && rvalid); i++) begin @(posedge clk); #1; end
    n_vec++;
    if (!wdone || !rdone || bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== old) begin
      n_err++; $display("FAIL rw_same_cycle got rdata=%h bvalid=%b rvalid=%b required %h 1 1",
                        rdata, bvalid, rvalid, old);
    end
    bready = 1'b1; rready = 1'b1; @(posedge clk); #1; bready = 1'b0; rready = 1'b0;
    if (wdone) model_write(5'h0C, nw, 4'hF);
    check_read(5'h0C, "rw_after_write");
  endtask

  task automatic test_stall();
    logic [31:0] a_dat, b_dat, held;
    bit hs;
    int bad;
    a_dat = $urandom; b_dat = $urandom;
    awaddr = 5'h08; wdata = a_dat; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin hs = awready && wready; @(posedge clk); #1; end
    if (hs) model_write(5'h08, a_dat, 4'hF);
    wdata = b_dat;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (!hs || bad != 0) begin
      n_err++; $display("FAIL b_stall got %0d bad cycles hs=%b required 0 and 1", bad, hs);
    end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin hs = awready && wready; @(posedge clk); #1; end
    awvalid = 1'b0; wvalid = 1'b0;
    if (hs) model_write(5'h08, b_dat, 4'hF);
    for (int i = 0; i < 20 && !bvalid; i++) begin @(posedge clk); #1; end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;

    araddr = 5'h08; arvalid = 1'b1; rready = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin hs = arready; @(posedge clk); #1; end
    held = model_read(5'h08);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== held) bad++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (!hs || bad != 0) begin
      n_err++; $display("FAIL r_stall got %0d bad cycles rdata=%h required 0 and %h", bad, rdata, held);
    end
    arvalid = 1'b0; rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit hs;
    axi_write(5'h00, 32'h0300_0040, 4'hF);
    awaddr = 5'h0C; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin hs = awready && wready; @(posedge clk); #1; end
    awvalid = 1'b0; wvalid = 1'b0;
    smp_in_valid = 1'b1; smp_in_l = 24'h010203; smp_in_r = 24'h040506;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if (!hs || bvalid !== 1'b1 || smp_out_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset got bvalid=%b smp_out_valid=%b required 1 1", bvalid, smp_out_valid);
    end
    rst = 1'b1; smp_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_vec++;
    if (bvalid !== 1'b0 || smp_out_valid !== 1'b0 || smp_out_l !== 24'h0 || smp_out_r !== 24'h0) begin
      n_err++; $display("FAIL midflight_reset got bvalid=%b v=%b l=%h r=%h required 0",
                        bvalid, smp_out_valid, smp_out_l, smp_out_r);
    end
    check_read(5'h00, "reg0_after_reset");
    check_read(5'h0C, "reg3_after_reset");
    run_stream(8, 80, 1'b0, 24'h0, 24'h0);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    smp_in_valid = 1'b0; smp_in_l = '0; smp_in_r = '0;
    model_reset();
    test_reset();
    test_regs();
    test_unity();
    test_saturate();
    test_random_gain();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
